trace_stream_tx: RTL and testbench

- Captures the processor's per-cycle debug observation bus (PC, instruction, ALU result, write-back data) into a record FIFO.
- Serializes each record as a byte stream over a valid/ready interface.
- Sits beside `processor` and replaces direct waveform probing. It drives trace data off-chip or to a bench-side receiver, which makes it the transmit end of the debug observation interface.

---
 rtl/trace_stream_tx.sv | 85 ++++++++
 tb/tb_trace_stream_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/trace_stream_tx.sv
// trace_stream_tx: buffers per-cycle debug records in a FIFO and streams them as bytes; define TRACE_HEADER_EN to prefix each record with sync byte 0xA5
module trace_stream_tx #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       pc_in,
  input  logic [7:0]       instr_in,
  input  logic [7:0]       alu_result_in,
  input  logic [7:0]       write_data_in,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic [7:0]       drop_count,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_SEND = 1'b1;
`ifdef TRACE_HEADER_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          state;
  logic [31:0]   record;
  logic [2:0]    byte_idx;
  logic          last_accept, pop, push, drop;
  logic [7:0]    cur_byte;
  // pop feeds the serializer when idle or when the last byte of a record is taken; a full FIFO still accepts a push on a pop cycle
  always_comb begin
    last_accept = state == STATE_SEND && tx_ready && byte_idx == LAST_IDX;
    pop         = fifo_count != '0 && (state == STATE_IDLE || last_accept);
    push        = enable && (fifo_count < CNT_W'(DEPTH) || pop);
    drop        = enable && !push;
`ifdef TRACE_HEADER_EN
    cur_byte    = byte_idx == 3'd0 ? 8'hA5 :
                  byte_idx == 3'd1 ? record[31:24] :
                  byte_idx == 3'd2 ? record[23:16] :
                  byte_idx == 3'd3 ? record[15:8] : record[7:0];
`else
    cur_byte    = byte_idx == 3'd0 ? record[31:24] :
                  byte_idx == 3'd1 ? record[23:16] :
                  byte_idx == 3'd2 ? record[15:8] : record[7:0];
`endif
    tx_valid    = state == STATE_SEND;
    tx_data     = tx_valid ? cur_byte : 8'h00;
  end
  // record storage needs no reset; pointers and count define validity
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= {pc_in, instr_in, alu_result_in, write_data_in};
  end
  // FIFO bookkeeping, drop accounting and the serializer FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      state      <= STATE_IDLE;
      record     <= '0;
      byte_idx   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        record   <= mem[rd_ptr];
        byte_idx <= '0;
        state    <= STATE_SEND;
      end else if (state == STATE_SEND && tx_ready) begin
        if (byte_idx == LAST_IDX) state <= STATE_IDLE;
        else byte_idx <= byte_idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_trace_stream_tx.sv
// tb_trace_stream_tx: directed self-checking bench for trace_stream_tx (honours TRACE_HEADER_EN)
module tb_trace_stream_tx;
`ifdef TRACE_HEADER_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  logic       clock = 1'b0;
  logic       reset, enable, tx_ready, tx_valid, overflow;
  logic [7:0] pc_in, instr_in, alu_result_in, write_data_in, tx_data, drop_count;
  logic [3:0] fifo_count;
  int n_cmp = 0;
  int n_err = 0;

  trace_stream_tx #(.DEPTH(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .pc_in(pc_in), .instr_in(instr_in), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] rec, input int k);
`ifdef TRACE_HEADER_EN
    if (k == 0) return 8'hA5;
    return 8'(rec >> (8 * (4 - k)));
`else
    return 8'(rec >> (8 * (3 - k)));
`endif
  endfunction

  function automatic logic [31:0] rec_of(input int i);
    logic [7:0] p;
    p = 8'(i);
    return {p, p ^ 8'hFF, p + 8'h40, p + 8'hC0};
  endfunction

  task automatic drive(input logic [31:0] rec);
    {pc_in, instr_in, alu_result_in, write_data_in} = rec;
  endtask

  task automatic expect_record(input string tag, input logic [31:0] rec);
    for (int k = 0; k < NB; k++) begin
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_data"}, 32'(tx_data), 32'(exp_byte(rec, k)));
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tx_ready = 1'b1; drive(32'h0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", 32'(tx_valid), 32'd0);
      chk("idle_count", 32'(fifo_count), 32'd0);
      chk("idle_drop", 32'(drop_count), 32'd0);
      chk("idle_ovf", 32'(overflow), 32'd0);
    end
    // single capture, 2-cycle latency
    drive(32'h045A1122); enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("lat_valid_n", 32'(tx_valid), 32'd0);
    chk("lat_count_n", 32'(fifo_count), 32'd1);
    tick();
    chk("lat_count_n1", 32'(fifo_count), 32'd0);
    expect_record("single", 32'h045A1122);
    chk("single_end", 32'(tx_valid), 32'd0);
    // backpressure holds first byte stable
    tx_ready = 1'b0; enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(tx_valid), 32'd1);
      chk("bp_data", 32'(tx_data), 32'(exp_byte(32'h045A1122, 0)));
      tick();
    end
    tx_ready = 1'b1;
    expect_record("bp", 32'h045A1122);
    chk("bp_end", 32'(tx_valid), 32'd0);
    // overflow: 1 in shift register, 8 in FIFO, 11 dropped
    tx_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(rec_of(i));
      tick();
    end
    enable = 1'b0;
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_drop", 32'(drop_count), 32'd11);
    chk("ovf_flag", 32'(overflow), 32'd1);
    tx_ready = 1'b1;
    for (int i = 0; i <= 8; i++) expect_record("ovf_drain", rec_of(i));
    chk("ovf_end_valid", 32'(tx_valid), 32'd0);
    chk("ovf_end_count", 32'(fifo_count), 32'd0);
    chk("ovf_end_drop", 32'(drop_count), 32'd11);
    // drop counter saturation
    tx_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(rec_of(i));
      tick();
    end
    chk("sat_drop", 32'(drop_count), 32'd255);
    chk("sat_count", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 32'(drop_count), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    // full FIFO with concurrent pops: pushes taken on pop cycles, count stays 8
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("simul_count", 32'(fifo_count), 32'd8);
      chk("simul_valid", 32'(tx_valid), 32'd1);
    end
    // reset with everything busy clears all state
    enable = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_valid", 32'(tx_valid), 32'd0);
    chk("rst2_count", 32'(fifo_count), 32'd0);
    chk("rst2_drop", 32'(drop_count), 32'd0);
    chk("rst2_ovf", 32'(overflow), 32'd0);
    // reset while byte 2 is on the bus
    drive(32'h31323334); enable = 1'b1;
    tick();
    enable = 1'b0;
    tick(); tick(); tick();
    chk("mid_data", 32'(tx_data), 32'(exp_byte(32'h31323334, 2)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", 32'(tx_valid), 32'd0);
    chk("mid_data0", 32'(tx_data), 32'd0);
    chk("mid_count", 32'(fifo_count), 32'd0);
    tick(); tick();
    chk("mid_stay_idle", 32'(tx_valid), 32'd0);
    drive(32'h51525354); enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    expect_record("post_rst", 32'h51525354);
    chk("post_rst_end", 32'(tx_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
